// File: rtl/alu_result_writeback_pkg.sv
// Shared definitions for the ALU result writeback stage: op codes, write
// targets and the writeback state encoding.
package alu_result_writeback_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  localparam logic WB_LO = 1'b0;
  localparam logic WB_HI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WR_LO = 2'b01,
    ST_WR_HI = 2'b10
  } wb_state_e;

endpackage

// File: rtl/alu_result_writeback_result_flag_gen.sv
// Condition flags for one ALU result. Mul/div judge the full 64-bit product,
// add/sub judge only the low half.
module result_flag_gen
  import alu_result_writeback_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] b,
  output logic             z,
  output logic             n,
  output logic             dz
);

  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    z  = 1'b0;
    n  = 1'b0;
    dz = (op == ALU_DIV) && (b == '0);
    if (op == ALU_MUL || op == ALU_DIV) begin
      z = ({hi, lo} == '0);
      n = hi[WIDTH-1];
    end else begin
      z = (lo == '0);
      n = lo[WIDTH-1];
    end
  end

endmodule

// File: rtl/alu_result_writeback.sv
// Captures one ALU result into the Z register pair, registers its flags and
// drives it to the write port as one or two valid/ready beats.
module alu_result_writeback
  import alu_result_writeback_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit HI_ON_ADDSUB = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] res_hi,
  input  logic [WIDTH-1:0] res_lo,
  input  logic [1:0]       res_op,
  input  logic [WIDTH-1:0] res_b,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_sel,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_dz
);

  wb_state_e        state_q, state_d;
  logic [WIDTH-1:0] z_hi_q, z_hi_d;
  logic [WIDTH-1:0] z_lo_q, z_lo_d;
  logic [1:0]       op_q, op_d;
  logic             wb_valid_q, wb_valid_d;
  logic             wb_sel_q, wb_sel_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_dz_q, flag_dz_d;
  logic             gen_z, gen_n, gen_dz;

  result_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .hi (res_hi),
    .lo (res_lo),
    .op (res_op),
    .b  (res_b),
    .z  (gen_z),
    .n  (gen_n),
    .dz (gen_dz)
  );

  assign res_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    z_hi_d     = z_hi_q;
    z_lo_d     = z_lo_q;
    op_d       = op_q;
    wb_valid_d = wb_valid_q;
    wb_sel_d   = wb_sel_q;
    wb_data_d  = wb_data_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    flag_dz_d  = flag_dz_q;

    case (state_q)
      ST_IDLE: begin
        if (res_valid) begin
          z_hi_d    = res_hi;
          z_lo_d    = res_lo;
          op_d      = res_op;
          flag_z_d  = gen_z;
          flag_n_d  = gen_n;
          flag_dz_d = gen_dz;
          // A divide by zero is recorded in the flags but never written back.
          if (!gen_dz) begin
            state_d    = ST_WR_LO;
            wb_valid_d = 1'b1;
            wb_sel_d   = WB_LO;
            wb_data_d  = res_lo;
          end
        end
      end
      ST_WR_LO: begin
        if (wb_ready) begin
          if (op_q == ALU_MUL || op_q == ALU_DIV || HI_ON_ADDSUB) begin
            state_d   = ST_WR_HI;
            wb_sel_d  = WB_HI;
            wb_data_d = z_hi_q;
          end else begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b0;
          end
        end
      end
      ST_WR_HI: begin
        if (wb_ready) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wb_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      z_hi_q     <= '0;
      z_lo_q     <= '0;
      op_q       <= ALU_ADD;
      wb_valid_q <= 1'b0;
      wb_sel_q   <= WB_LO;
      wb_data_q  <= '0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_dz_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      z_hi_q     <= z_hi_d;
      z_lo_q     <= z_lo_d;
      op_q       <= op_d;
      wb_valid_q <= wb_valid_d;
      wb_sel_q   <= wb_sel_d;
      wb_data_q  <= wb_data_d;
      flag_z_q   <= flag_z_d;
      flag_n_q   <= flag_n_d;
      flag_dz_q  <= flag_dz_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_sel   = wb_sel_q;
  assign wb_data  = wb_data_q;
  assign flag_z   = flag_z_q;
  assign flag_n   = flag_n_q;
  assign flag_dz  = flag_dz_q;

endmodule
